// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the front-panel execution controller.
// Mode codes equal the state encoding so mode can be driven straight from the state register.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT     = 2'b00,
        ST_STEP     = 2'b01,
        ST_RUN      = 2'b10,
        ST_HALT_REQ = 2'b11
    } state_t;

    localparam logic [1:0] MODE_HALT     = 2'b00;
    localparam logic [1:0] MODE_STEP     = 2'b01;
    localparam logic [1:0] MODE_RUN      = 2'b10;
    localparam logic [1:0] MODE_HALT_REQ = 2'b11;

    localparam int WDOG_W = 28;

    function automatic logic [WDOG_W-1:0] timeout_clk(input int unsigned clk_frq,
                                                      input int unsigned timeout_ms);
        int unsigned cycles;
        cycles = (clk_frq / 32'd1000) * timeout_ms;
        return cycles[WDOG_W-1:0];
    endfunction

endpackage

// File: rtl/step_ctrl_timeout_timer.sv
// Watchdog counter: counts while enabled, held at zero otherwise, and
// pulses expire for one cycle when the count reaches the terminal value.
module timeout_timer #(
    parameter int                CNT_W    = 28,
    parameter logic [CNT_W-1:0]  TERMINAL = '1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The owner leaves the enabling state on expiry, so the pulse is naturally one cycle.
    assign expire = enable && (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Front-panel execution controller: turns debounced switch events into the CPU
// run-enable, halting only at instruction-fetch boundaries, with a watchdog fallback.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FRQ    = 27_000_000,
    parameter int unsigned TIMEOUT_MS = 100,
    parameter int unsigned WIDTH      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_pulse,
    input  logic             rpt_in,
    input  logic             run_pulse,
    input  logic             cpu_ifetch,
    input  logic             cpu_hlt,
    output logic             run_en,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] step_cnt,
    output logic             timeout_err
);

    localparam logic [WDOG_W-1:0] TIMEOUT_CLK = timeout_clk(CLK_FRQ, TIMEOUT_MS);

    state_t           state_q, state_d;
    logic             rpt_q;
    logic             pending_q, pending_d;
    logic             run_en_q;
    logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic step_req;
    logic wdog_en;
    logic wdog_clear;
    logic wdog_expire;

    assign step_req   = step_pulse | (rpt_in & ~rpt_q);
    assign wdog_en    = (state_q == ST_STEP) || (state_q == ST_HALT_REQ);
    assign wdog_clear = (state_d != state_q) &&
                        ((state_d == ST_STEP) || (state_d == ST_HALT_REQ));

    timeout_timer #(
        .CNT_W    (WDOG_W),
        .TERMINAL (TIMEOUT_CLK)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wdog_clear),
        .enable  (wdog_en),
        .expire  (wdog_expire)
    );

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        step_cnt_d    = step_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_HALT: begin
                // Run wins over a simultaneous step; a queued step is discarded too.
                if (run_pulse) begin
                    state_d       = ST_RUN;
                    pending_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end else if (step_req || pending_q) begin
                    state_d       = ST_STEP;
                    pending_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (cpu_ifetch) begin
                    state_d    = ST_HALT;
                    step_cnt_d = step_cnt_q + 1'b1;
                end else if (cpu_hlt) begin
                    state_d = ST_HALT;
                end else if (wdog_expire) begin
                    state_d       = ST_HALT;
                    timeout_err_d = 1'b1;
                end else if (run_pulse) begin
                    state_d = ST_RUN;
                end
                if (step_req && (state_d != ST_RUN)) begin
                    pending_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cpu_hlt) begin
                    state_d = ST_HALT;
                end else if (run_pulse) begin
                    state_d = cpu_ifetch ? ST_HALT : ST_HALT_REQ;
                end
            end
            ST_HALT_REQ: begin
                if (cpu_ifetch || cpu_hlt) begin
                    state_d = ST_HALT;
                end else if (wdog_expire) begin
                    state_d       = ST_HALT;
                    timeout_err_d = 1'b1;
                end else if (run_pulse) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_HALT;
            rpt_q         <= 1'b0;
            pending_q     <= 1'b0;
            run_en_q      <= 1'b0;
            step_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rpt_q         <= rpt_in;
            pending_q     <= pending_d;
            run_en_q      <= (state_q != ST_HALT);
            step_cnt_q    <= step_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign run_en      = run_en_q;
    assign mode        = state_q;
    assign step_cnt    = step_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_step_ctrl;

    localparam int W = 3;
    localparam logic [1:0] M_HALT = 2'b00;
    localparam logic [1:0] M_STEP = 2'b01;
    localparam logic [1:0] M_RUN  = 2'b10;
    localparam logic [1:0] M_HREQ = 2'b11;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         step_pulse = 1'b0;
    logic         rpt_in = 1'b0;
    logic         run_pulse = 1'b0;
    logic         cpu_ifetch = 1'b0;
    logic         cpu_hlt = 1'b0;
    logic         run_en;
    logic [1:0]   mode;
    logic [W-1:0] step_cnt;
    logic         timeout_err;

    step_ctrl #(
        .CLK_FRQ    (1_000_000),
        .TIMEOUT_MS (1),
        .WIDTH      (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .step_pulse  (step_pulse),
        .rpt_in      (rpt_in),
        .run_pulse   (run_pulse),
        .cpu_ifetch  (cpu_ifetch),
        .cpu_hlt     (cpu_hlt),
        .run_en      (run_en),
        .mode        (mode),
        .step_cnt    (step_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           at;
        string        name;
        logic         re;
        logic [1:0]   md;
        logic [W-1:0] cnt;
        logic         te;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic expect_at(input int dly, input string nm, input logic re,
                             input logic [1:0] md, input int cnt, input logic te);
        exp_t e;
        e.at   = cyc + dly;
        e.name = nm;
        e.re   = re;
        e.md   = md;
        e.cnt  = W'(cnt);
        e.te   = te;
        sb.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.at != cyc || run_en !== e.re || mode !== e.md ||
                step_cnt !== e.cnt || timeout_err !== e.te) begin
                $display("FAIL %s cyc=%0d: got run_en=%b mode=%b cnt=%0d terr=%b, want run_en=%b mode=%b cnt=%0d terr=%b (due cyc %0d)",
                         e.name, cyc, run_en, mode, step_cnt, timeout_err,
                         e.re, e.md, e.cnt, e.te, e.at);
            end else begin
                passes++;
                $display("check %s cyc=%0d ok run_en=%b mode=%b cnt=%0d terr=%b",
                         e.name, cyc, run_en, mode, step_cnt, timeout_err);
            end
        end
    end

    int base;

    initial begin
        tick(3);
        expect_at(0, "reset_state", 0, M_HALT, 0, 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);

        // single step: STEP next cycle, run_en one later, halt two after ifetch
        step_pulse = 1'b1;
        expect_at(1, "step_mode", 0, M_STEP, 0, 0);
        expect_at(2, "step_run_en", 1, M_STEP, 0, 0);
        expect_at(6, "step_hold", 1, M_STEP, 0, 0);
        tick(); step_pulse = 1'b0;
        tick(9);
        cpu_ifetch = 1'b1;
        expect_at(1, "ifetch_halt", 1, M_HALT, 1, 0);
        expect_at(2, "ifetch_run_off", 0, M_HALT, 1, 0);
        tick(); cpu_ifetch = 1'b0;
        tick(3);

        // two requests during STEP give exactly one pending step
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        tick();
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        cpu_ifetch = 1'b1;
        expect_at(1, "pend_halt", 1, M_HALT, 2, 0);
        expect_at(2, "pend_relaunch", 0, M_STEP, 2, 0);
        expect_at(3, "pend_run_en", 1, M_STEP, 2, 0);
        tick(); cpu_ifetch = 1'b0;
        tick(2);
        cpu_ifetch = 1'b1;
        expect_at(1, "pend_done", 1, M_HALT, 3, 0);
        expect_at(2, "pend_run_off", 0, M_HALT, 3, 0);
        expect_at(5, "pend_only_one", 0, M_HALT, 3, 0);
        tick(); cpu_ifetch = 1'b0;
        tick(5);

        // run, then halt request waits for boundary; step ignored in RUN
        run_pulse = 1'b1;
        expect_at(1, "run_enter", 0, M_RUN, 3, 0);
        expect_at(2, "run_en_on", 1, M_RUN, 3, 0);
        tick(); run_pulse = 1'b0;
        tick(2);
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        run_pulse = 1'b1;
        expect_at(1, "halt_req", 1, M_HREQ, 3, 0);
        expect_at(4, "halt_req_hold", 1, M_HREQ, 3, 0);
        tick(); run_pulse = 1'b0;
        tick(3);
        cpu_ifetch = 1'b1;
        expect_at(1, "hreq_halt", 1, M_HALT, 3, 0);
        expect_at(2, "hreq_run_off", 0, M_HALT, 3, 0);
        expect_at(4, "run_step_ignored", 0, M_HALT, 3, 0);
        tick(); cpu_ifetch = 1'b0;
        tick(3);
        run_pulse = 1'b1; tick(); run_pulse = 1'b0;
        tick(3);
        run_pulse = 1'b1;
        cpu_ifetch = 1'b1;
        expect_at(1, "direct_halt", 1, M_HALT, 3, 0);
        expect_at(2, "direct_run_off", 0, M_HALT, 3, 0);
        tick(); run_pulse = 1'b0; cpu_ifetch = 1'b0;
        tick(2);

        // watchdog: 1000-cycle terminal count
        step_pulse = 1'b1;
        expect_at(1, "wdog_step", 0, M_STEP, 3, 0);
        expect_at(1001, "wdog_last", 1, M_STEP, 3, 0);
        expect_at(1002, "wdog_expire", 1, M_HALT, 3, 1);
        expect_at(1003, "wdog_run_off", 0, M_HALT, 3, 1);
        tick(); step_pulse = 1'b0;
        tick(1005);
        run_pulse = 1'b1;
        expect_at(1, "terr_cleared", 0, M_RUN, 3, 0);
        tick(); run_pulse = 1'b0;
        tick(2);
        run_pulse = 1'b1; cpu_ifetch = 1'b1;
        expect_at(1, "wdog_back_halt", 1, M_HALT, 3, 0);
        tick(); run_pulse = 1'b0; cpu_ifetch = 1'b0;
        tick(3);

        // auto-repeat: five rising edges, count wraps past 7
        for (int i = 0; i < 5; i++) begin
            rpt_in = 1'b1;
            expect_at(1, $sformatf("rpt%0d_step", i), 0, M_STEP, 3 + i, 0);
            expect_at(2, $sformatf("rpt%0d_run_en", i), 1, M_STEP, 3 + i, 0);
            tick(2);
            rpt_in = 1'b0;
            tick(3);
            cpu_ifetch = 1'b1;
            expect_at(1, $sformatf("rpt%0d_halt", i), 1, M_HALT, 4 + i, 0);
            tick(); cpu_ifetch = 1'b0;
            tick(2);
        end
        expect_at(4, "rpt_no_extra", 0, M_HALT, 8, 0);
        tick(6);

        // reset during RUN and during STEP
        run_pulse = 1'b1; tick(); run_pulse = 1'b0;
        tick(2);
        reset_n = 1'b0;
        expect_at(1, "reset_in_run", 0, M_HALT, 0, 0);
        tick(); reset_n = 1'b1;
        tick(2);
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        tick(2);
        reset_n = 1'b0;
        expect_at(1, "reset_in_step", 0, M_HALT, 0, 0);
        tick(); reset_n = 1'b1;
        tick(2);

        // cpu_hlt in RUN halts without counting
        step_pulse = 1'b1; tick(); step_pulse = 1'b0;
        tick(2);
        cpu_ifetch = 1'b1;
        expect_at(1, "pre_hlt_step", 1, M_HALT, 1, 0);
        tick(); cpu_ifetch = 1'b0;
        tick(2);
        run_pulse = 1'b1; tick(); run_pulse = 1'b0;
        tick(2);
        cpu_hlt = 1'b1;
        expect_at(1, "hlt_halt", 1, M_HALT, 1, 0);
        expect_at(2, "hlt_run_off", 0, M_HALT, 1, 0);
        tick(); cpu_hlt = 1'b0;
        tick(4);

        if (sb.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
